nibble_adder_arbiter: RTL and testbench
=======================================

Name: nibble_adder_arbiter

Overview:
- Shares one 4-bit add slice between two requesters and sequences WIDTH-bit additions nibble-serially, LSB nibble first, with a registered carry between nibbles.
- Arbitration between requesters is round-robin.
- Results come out on a valid/ready result port tagged with the requester ID.
- Sits between client logic and the small-adder datapath. The add slice is internal: a 4-bit add with carry-in and a 5-bit result.

Parameters:
WIDTH  16  operand width in bits; must be a multiple of 4 and at least 4
NIB  WIDTH/4  number of nibble steps per operation (derived, not overridable)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  synchronous, active-high reset
i_req0_valid  input  1  requester 0 has an operation
i_req0_a  input  WIDTH  requester 0 operand A
i_req0_b  input  WIDTH  requester 0 operand B
o_req0_ready  output  1  requester 0 operation accepted this cycle
i_req1_valid  input  1  requester 1 has an operation
i_req1_a  input  WIDTH  requester 1 operand A
i_req1_b  input  WIDTH  requester 1 operand B
o_req1_ready  output  1  requester 1 operation accepted this cycle
o_res_valid  output  1  result available
o_res_sum  output  WIDTH  sum bits [WIDTH-1:0]
o_res_carry  output  1  carry out of the MSB nibble
o_res_id  output  1  requester that owns the result (0/1)
i_res_ready  input  1  consumer accepts result
o_busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset state: IDLE, rr pointer = 0, nibble count = 0, internal carry = 0.
- Reset values: o_res_valid = 0, o_res_sum = 0, o_res_carry = 0, o_res_id = 0, o_busy = 0, both readies = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester equal to rr pointer wins.
- IDLE, handshake:
  - Winner's ready is combinational high in the same cycle; the loser's ready is 0.
  - Handshake = valid & ready.
  - On handshake: latch A, B and id; clear the sum register, carry and count; set rr pointer = ~id; go to RUN.
  - No valid: stay in IDLE.
- Readies are 0 in RUN and DONE. Requesters must hold valid and operands stable until ready. Operands changing while valid and not ready is a requester error; no checking is done.
- RUN, one nibble per cycle (k = count):
  - {c, s} = A[4k+3:4k] + B[4k+3:4k] + carry
  - sum[4k+3:4k] <= s; carry <= c; count <= count + 1.
  - When k = NIB-1, go to DONE.
  - RUN lasts exactly NIB cycles.
- DONE:
  - o_res_valid = 1.
  - o_res_sum, o_res_carry and o_res_id are registered and held stable until the handshake.
  - On i_res_ready, go to IDLE. o_res_valid deasserts the next cycle.
  - While i_res_ready = 0, stay in DONE; data does not change.
- Latency: handshake in cycle T, o_res_valid high from cycle T+NIB+1.
- Throughput: at best one operation per NIB+2 cycles (accept, NIB run cycles, DONE with immediate ready).
- No acceptance in DONE, even when i_res_ready is high in that cycle. The next request is accepted in the following IDLE cycle.
- Arithmetic is unsigned modulo 2^WIDTH; the carry out goes to o_res_carry.
- Example: all-ones + 1 gives sum 0, carry 1.
- o_res_sum/o_res_carry/o_res_id outside DONE hold their last value; after reset they are 0. Only o_res_valid qualifies them.
- Reset mid-RUN or mid-DONE: abort; no result is emitted; all reset values apply next cycle; rr pointer returns to 0.
- Reset has priority over any simultaneous handshake.

Test Plan:
- Basic add: reset, then req0 A=0x1234, B=0x0101 -> ready0 high in the accept cycle; o_res_valid exactly 5 cycles later; sum=0x1335, carry=0, id=0.
- Carry chain: req1 A=0xFFFF, B=0x0001 -> sum=0x0000, carry=1, id=1. Also A=0x0FFF, B=0x0001 -> sum=0x1000, carry=0.
- Round-robin: both valid continuously; req0 A=1,B=1, req1 A=2,B=2, i_res_ready=1 -> grant order 0,1,0,1; sums 2,4,2,4; readies never both high.
- Back-pressure: i_res_ready=0 for 10 cycles after valid -> o_res_valid, sum, carry and id stay stable, readies stay 0. Raising ready -> valid drops next cycle and a new grant can occur one cycle later.
- Reset mid-operation: assert i_rst during the 2nd RUN cycle -> next cycle o_busy=0, o_res_valid=0, outputs 0; a following req1-only request is granted and produces the correct sum.
- Single requester fairness: only req1 valid for 3 back-to-back ops -> all three granted to req1 with no idle gaps beyond IDLE. Then both valid -> req0 is granted first (pointer = ~1 = 0).

Source files
------------

// File: rtl/nibble_adder_arbiter.sv
// nibble_adder_arbiter
// Two requesters share a single 4-bit add slice. A WIDTH-bit addition is
// performed nibble-serially, least significant nibble first, with a registered
// carry between nibbles. Requesters are arbitrated round-robin. The result is
// presented on a valid/ready port, tagged with the owning requester.

module nibble_adder_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_req1_ready,
  output logic             o_res_valid,
  output logic [WIDTH-1:0] o_res_sum,
  output logic             o_res_carry,
  output logic             o_res_id,
  input  logic             i_res_ready,
  output logic             o_busy
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             rr_ptr;
  logic [CNT_W-1:0] count;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             id_reg;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_carry_q;
  logic             res_id_q;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic [4:0]       slice_sum;
  logic [WIDTH-1:0] sum_next;
  logic             last_nib;

  // Round-robin pick: a lone requester always wins, a tie goes to rr_ptr.
  always_comb begin
    grant0 = i_req0_valid & (~i_req1_valid | (rr_ptr == 1'b0));
    grant1 = i_req1_valid & (~i_req0_valid | (rr_ptr == 1'b1));
  end

  // The shared 4-bit slice; operands are shifted down so the active nibble is always at [3:0].
  always_comb begin
    slice_sum = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, carry};
    last_nib  = (count == LAST_CNT);
    sum_next  = sum_reg;
    for (int k = 0; k < NIB; k++) begin
      if (count == CNT_W'(k)) begin
        sum_next[4*k +: 4] = slice_sum[3:0];
      end
    end
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, NIB cycles of RUN, hold in DONE until consumed.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = RUN;
      RUN:     if (last_nib)    state_next = DONE;
      DONE:    if (i_res_ready) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; readies are masked by reset so reset wins over a handshake.
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    if (state == IDLE && !i_rst) begin
      o_req0_ready = grant0;
      o_req1_ready = grant1;
    end
    accept      = o_req0_ready | o_req1_ready;
    o_res_valid = (state == DONE);
    o_busy      = (state != IDLE);
    o_res_sum   = res_sum_q;
    o_res_carry = res_carry_q;
    o_res_id    = res_id_q;
  end

  // Datapath: latch operands on accept, add one nibble per RUN cycle, capture the result on the last nibble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr      <= 1'b0;
      count       <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      id_reg      <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= o_req1_ready ? i_req1_a : i_req0_a;
            b_reg   <= o_req1_ready ? i_req1_b : i_req0_b;
            id_reg  <= o_req1_ready;
            rr_ptr  <= ~o_req1_ready;
            sum_reg <= '0;
            carry   <= 1'b0;
            count   <= '0;
          end
        end
        RUN: begin
          sum_reg <= sum_next;
          carry   <= slice_sum[4];
          a_reg   <= a_reg >> 4;
          b_reg   <= b_reg >> 4;
          count   <= count + CNT_W'(1);
          if (last_nib) begin
            res_sum_q   <= sum_next;
            res_carry_q <= slice_sum[4];
            res_id_q    <= id_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_adder_arbiter.sv
// tb_nibble_adder_arbiter
// Directed bench for the nibble-serial shared adder with round-robin arbitration.

module tb_nibble_adder_arbiter;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             i_clk;
  logic             i_rst;
  logic             i_req0_valid;
  logic [WIDTH-1:0] i_req0_a;
  logic [WIDTH-1:0] i_req0_b;
  logic             o_req0_ready;
  logic             i_req1_valid;
  logic [WIDTH-1:0] i_req1_a;
  logic [WIDTH-1:0] i_req1_b;
  logic             o_req1_ready;
  logic             o_res_valid;
  logic [WIDTH-1:0] o_res_sum;
  logic             o_res_carry;
  logic             o_res_id;
  logic             i_res_ready;
  logic             o_busy;

  int checks_done;
  int fail_count;

  nibble_adder_arbiter #(.WIDTH(WIDTH)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req0_valid (i_req0_valid),
    .i_req0_a     (i_req0_a),
    .i_req0_b     (i_req0_b),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_a     (i_req1_a),
    .i_req1_b     (i_req1_b),
    .o_req1_ready (o_req1_ready),
    .o_res_valid  (o_res_valid),
    .o_res_sum    (o_res_sum),
    .o_res_carry  (o_res_carry),
    .o_res_id     (o_res_id),
    .i_res_ready  (i_res_ready),
    .o_busy       (o_busy)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_done++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (id) begin
      i_req1_valid = 1'b1;
      i_req1_a     = a;
      i_req1_b     = b;
    end else begin
      i_req0_valid = 1'b1;
      i_req0_a     = a;
      i_req0_b     = b;
    end
  endtask

  // One complete operation from an IDLE cycle through an immediately consumed result.
  task automatic do_op(input string tag, input logic id, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_sum,
                       input logic exp_carry);
    apply_stimulus(id, a, b);
    #1;
    check_output({tag, " ready0"}, o_req0_ready, !id);
    check_output({tag, " ready1"}, o_req1_ready, id);
    tick();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      check_output({tag, " valid low in run"}, o_res_valid, 1'b0);
      check_output({tag, " busy in run"}, o_busy, 1'b1);
      tick();
    end
    check_output({tag, " valid"}, o_res_valid, 1'b1);
    check_output({tag, " sum"}, o_res_sum, exp_sum);
    check_output({tag, " carry"}, o_res_carry, exp_carry);
    check_output({tag, " id"}, o_res_id, id);
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    check_output({tag, " valid drop"}, o_res_valid, 1'b0);
    check_output({tag, " idle"}, o_busy, 1'b0);
  endtask

  initial begin
    logic             exp_id [4];
    logic [WIDTH-1:0] exp_sum [4];

    checks_done  = 0;
    fail_count   = 0;
    i_rst        = 1'b1;
    i_req0_valid = 1'b0;
    i_req0_a     = '0;
    i_req0_b     = '0;
    i_req1_valid = 1'b0;
    i_req1_a     = '0;
    i_req1_b     = '0;
    i_res_ready  = 1'b0;

    tick();
    tick();
    i_req0_valid = 1'b1;
    #1;
    check_output("ready0 held by reset", o_req0_ready, 1'b0);
    check_output("reset busy", o_busy, 1'b0);
    check_output("reset valid", o_res_valid, 1'b0);
    check_output("reset sum", o_res_sum, 16'h0000);
    check_output("reset carry", o_res_carry, 1'b0);
    check_output("reset id", o_res_id, 1'b0);
    i_req0_valid = 1'b0;
    i_rst = 1'b0;
    tick();

    // Basic add and carry chain; pointer ends at 0 after the req1 operations.
    do_op("basic", 1'b0, 16'h1234, 16'h0101, 16'h1335, 1'b0);
    do_op("carry all", 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    do_op("carry part", 1'b1, 16'h0FFF, 16'h0001, 16'h1000, 1'b0);

    // Round-robin with both requesters always valid.
    exp_id[0] = 1'b0; exp_sum[0] = 16'h0002;
    exp_id[1] = 1'b1; exp_sum[1] = 16'h0004;
    exp_id[2] = 1'b0; exp_sum[2] = 16'h0002;
    exp_id[3] = 1'b1; exp_sum[3] = 16'h0004;
    apply_stimulus(1'b0, 16'h0001, 16'h0001);
    apply_stimulus(1'b1, 16'h0002, 16'h0002);
    i_res_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      #1;
      check_output("rr ready0", o_req0_ready, !exp_id[op]);
      check_output("rr ready1", o_req1_ready, exp_id[op]);
      tick();
      check_output("rr ready0 in run", o_req0_ready, 1'b0);
      check_output("rr ready1 in run", o_req1_ready, 1'b0);
      for (int i = 0; i < NIB; i++) tick();
      check_output("rr valid", o_res_valid, 1'b1);
      check_output("rr sum", o_res_sum, exp_sum[op]);
      check_output("rr id", o_res_id, exp_id[op]);
      tick();
    end
    i_res_ready  = 1'b0;
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;

    // Back-pressure: result held for 10 cycles while req1 waits.
    apply_stimulus(1'b0, 16'h00FF, 16'h0F01);
    #1;
    check_output("bp ready0", o_req0_ready, 1'b1);
    tick();
    i_req0_valid = 1'b0;
    apply_stimulus(1'b1, 16'h8000, 16'h8000);
    for (int i = 0; i < NIB; i++) tick();
    for (int i = 0; i < 10; i++) begin
      check_output("bp valid", o_res_valid, 1'b1);
      check_output("bp sum", o_res_sum, 16'h1000);
      check_output("bp carry", o_res_carry, 1'b0);
      check_output("bp id", o_res_id, 1'b0);
      check_output("bp ready1", o_req1_ready, 1'b0);
      tick();
    end
    i_res_ready = 1'b1;
    #1;
    check_output("no accept in done", o_req1_ready, 1'b0);
    tick();
    i_res_ready = 1'b0;
    check_output("bp valid drop", o_res_valid, 1'b0);
    check_output("bp new grant", o_req1_ready, 1'b1);
    tick();
    i_req1_valid = 1'b0;
    for (int i = 0; i < NIB; i++) tick();
    check_output("bp2 sum", o_res_sum, 16'h0000);
    check_output("bp2 carry", o_res_carry, 1'b1);
    check_output("bp2 id", o_res_id, 1'b1);
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;

    // Reset during the second RUN cycle of a req0 operation.
    apply_stimulus(1'b0, 16'h1111, 16'h2222);
    #1;
    check_output("abort ready0", o_req0_ready, 1'b1);
    tick();
    i_req0_valid = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_output("abort busy", o_busy, 1'b0);
    check_output("abort valid", o_res_valid, 1'b0);
    check_output("abort sum", o_res_sum, 16'h0000);
    check_output("abort carry", o_res_carry, 1'b0);
    check_output("abort id", o_res_id, 1'b0);
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    #1;
    check_output("abort rr ready0", o_req0_ready, 1'b1);
    check_output("abort rr ready1", o_req1_ready, 1'b0);
    i_req0_valid = 1'b0;
    do_op("after abort", 1'b1, 16'h7777, 16'h1111, 16'h8888, 1'b0);

    // Single requester back-to-back, then a tie goes to req0.
    do_op("solo a", 1'b1, 16'h0001, 16'h0002, 16'h0003, 1'b0);
    do_op("solo b", 1'b1, 16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0);
    do_op("solo c", 1'b1, 16'h8001, 16'h8001, 16'h0002, 1'b1);
    apply_stimulus(1'b0, 16'h0003, 16'h0004);
    apply_stimulus(1'b1, 16'h0005, 16'h0006);
    #1;
    check_output("tie ready0", o_req0_ready, 1'b1);
    check_output("tie ready1", o_req1_ready, 1'b0);
    tick();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    for (int i = 0; i < NIB; i++) tick();
    check_output("tie sum", o_res_sum, 16'h0007);
    check_output("tie id", o_res_id, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, fail_count);
    $finish;
  end

endmodule
